// File: rtl/serial_adder16_pkg.sv
// Shared definitions for the bit-serial adder.
// State encoding and default width are reused by the benches.
package serial_adder16_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder16_fa.sv
// One-bit full-adder cell; the only arithmetic
// element in the serial adder datapath.
module serial_adder16_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder16.sv
// Bit-serial adder: one full-adder step per clock,
// LSB first, fixed WIDTH+1 cycle latency to done_o.
module serial_adder16
  import serial_adder16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t nstate;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [CW-1:0]    cnt;
  logic             cf;
  logic             fs;
  logic             fco;
  logic             last;
  logic             accept;

  assign last   = (cnt == LAST);
  assign accept = (state == IDLE) && start_i;

  serial_adder16_fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (cf),
    .s  (fs),
    .co (fco)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start_i) nstate = RUN;
      RUN:     if (last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state)
      IDLE:    ready_o = 1'b1;
      RUN:     busy_o  = 1'b1;
      DONE:    done_o  = 1'b1;
      default: ready_o = 1'b0;
    endcase
  end

  // Operands shift right; sum bits enter at the MSB so
  // the register holds the aligned result after WIDTH steps.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      cnt  <= '0;
      cf   <= 1'b0;
    end else if (accept) begin
      a_sh <= a_i;
      b_sh <= b_i;
      s_sh <= '0;
      cnt  <= '0;
      cf   <= c_i;
    end else if (state == RUN) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      s_sh <= {fs, s_sh[WIDTH-1:1]};
      cf   <= fco;
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  // Result registers change only on the final step.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_o   <= '0;
      carry_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else if (state == RUN && last) begin
      sum_o   <= {fs, s_sh[WIDTH-1:1]};
      carry_o <= fco;
      ovf_o   <= cf ^ fco;
    end
  end

endmodule

// File: tb/tb_serial_adder16.sv
// Scoreboard bench for serial_adder16: directed vectors,
// abort-by-reset, ignored start and back-to-back issue.
module tb_serial_adder16;
  import serial_adder16_pkg::*;

  localparam int W = WIDTH_DEF;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         carry_o;
  logic         ovf_o;

  exp_t         q[$];
  exp_t         me;
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  logic [W-1:0] last_s   = '0;
  logic         last_co  = 1'b0;
  logic         last_ov  = 1'b0;

  serial_adder16 #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .c_i     (c),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .carry_o (carry_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic ci);
    exp_t r;
    logic [W:0] t;
    t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    r.s  = t[W-1:0];
    r.co = t[W];
    r.ov = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    r.acc = 0;
    return r;
  endfunction

  // Monitor: pops on every done pulse, checks hold during RUN.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done_o === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        me = q.pop_front();
        chk("sum", 64'(sum_o), 64'(me.s));
        chk("carry", 64'(carry_o), 64'(me.co));
        chk("ovf", 64'(ovf_o), 64'(me.ov));
        chk("latency", 64'(cyc - me.acc), 64'(W + 1));
        last_s  = me.s;
        last_co = me.co;
        last_ov = me.ov;
      end
    end else if (rst_n === 1'b1 && busy_o === 1'b1) begin
      chk("hold_result", 64'({sum_o, carry_o, ovf_o}),
          64'({last_s, last_co, last_ov}));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || ready_o !== 1'b1) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input logic ci,
                       input logic [W-1:0] es,
                       input logic eco,
                       input logic eov,
                       input bit track);
    exp_t e;
    wait_ready();
    a     = x;
    b     = y;
    c     = ci;
    start = 1'b1;
    e.s   = es;
    e.co  = eco;
    e.ov  = eov;
    e.acc = cyc;
    @(posedge clk);
    if (track) q.push_back(e);
    #1;
    start = 1'b0;
    a     = ~x;
    b     = ~y;
    c     = ~ci;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_sum"}, 64'(sum_o), 64'd0);
    chk({tag, "_carry"}, 64'(carry_o), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf_o), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   prev;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c     = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

    issue(16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    a     = 16'h1111;
    b     = 16'h2222;
    c     = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;
    chk("ignored_start_no_rerun", 64'(busy_o), 64'd0);

    issue(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n   = 1'b0;
    last_s  = '0;
    last_co = 1'b0;
    last_ov = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    chk("abort_hold_done", 64'(done_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    wait_idle();

    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      c     = 1'($urandom);
      start = 1'b1;
      e     = model(a, b, c);
      wait_ready();
      e.acc = cyc;
      @(posedge clk);
      q.push_back(e);
      if (i > 0) chk("issue_interval", 64'(cyc - prev), 64'(W + 2));
      prev = cyc;
      #1;
    end
    start = 1'b0;
    wait_idle();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
